// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO register file and sequential-multiplier issue controller
// for the EX stage. Decodes MULT/MULTU/MFHI/MFLO/MTHI/MTLO, launches the
// multiplier with a one-cycle start pulse, stalls EX until the product
// returns, then commits {hi,lo}.
// Optional feature macro: HILO_TIMEOUT_EN (WAIT watchdog with sticky err).
module hilo_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic [2:0]         op_code,
  input  logic [WIDTH-1:0]   rs_data,
  input  logic [WIDTH-1:0]   rt_data,
  output logic               stall,
  output logic [WIDTH-1:0]   rd_data,
  output logic               rd_valid,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_signed,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               err
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_is_mul;
  logic             w_commit;
  logic             w_timeout;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_mul_a;
  logic [WIDTH-1:0] r_mul_b;
  logic             r_mul_signed;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  // Ops are only consumed in IDLE; stall is a pure decode of the state register.
  assign w_accept = op_valid && (r_state == S_IDLE);
  assign w_is_mul = w_accept && (op_code[2:1] == 2'b00);
  assign w_commit = (r_state == S_WAIT) && mul_done;

`ifdef HILO_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  assign w_timeout = (r_state == S_WAIT) && !mul_done &&
                     (r_cnt == CNT_W'(TIMEOUT - 1));

  // WAIT-cycle counter (cleared in LAUNCH) and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == S_LAUNCH)    r_cnt <= '0;
      else if (r_state == S_WAIT) r_cnt <= r_cnt + CNT_W'(1);
      if (w_timeout)              r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT + CNT_W);
  assign w_timeout        = 1'b0;
  assign err              = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_is_mul) w_state_nxt = S_LAUNCH;
      S_LAUNCH: w_state_nxt = S_WAIT;
      S_WAIT:   if (mul_done || w_timeout) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // HI/LO, operand latches and MFHI/MFLO read port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hi         <= '0;
      r_lo         <= '0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_mul_signed <= 1'b0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_accept) begin
        case (op_code)
          3'b000, 3'b001: begin
            r_mul_a      <= rs_data;
            r_mul_b      <= rt_data;
            r_mul_signed <= ~op_code[0];
          end
          3'b010: begin
            r_rd_data  <= r_hi;
            r_rd_valid <= 1'b1;
          end
          3'b011: begin
            r_rd_data  <= r_lo;
            r_rd_valid <= 1'b1;
          end
          3'b100:  r_hi <= rs_data;
          3'b101:  r_lo <= rs_data;
          default: ;
        endcase
      end
      if (w_commit) begin
        r_hi <= mul_product[2*WIDTH-1:WIDTH];
        r_lo <= mul_product[WIDTH-1:0];
      end
    end
  end

  assign stall      = (r_state != S_IDLE);
  assign mul_start  = (r_state == S_LAUNCH);
  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;
  assign mul_signed = r_mul_signed;
  assign rd_data    = r_rd_data;
  assign rd_valid   = r_rd_valid;
  assign hi         = r_hi;
  assign lo         = r_lo;

endmodule

// File: doc/hilo_ctrl.md
# hilo_ctrl

HI/LO register and multiply-issue controller for the EX stage of the MIPS core. It decodes MULT/MULTU/MFHI/MFLO/MTHI/MTLO requests and launches the sequential multiplier with a one-cycle start pulse. While the multiply runs, it holds the pipeline with `stall`, then commits the 64-bit product into HI/LO. It sits directly upstream of the multiplier (feeds operands) and downstream of it (consumes the product).

## Interface
- `WIDTH`, 32, operand/register width
- `TIMEOUT`, 200, max cycles to wait for `mul_done` (used only with `HILO_TIMEOUT_EN`)

- `clk` in 1: clock, rising edge
- `rst` in 1: reset; synchronous, active-low
- `op_valid` in 1: EX presents a HI/LO op this cycle
- `op_code` in 3: 000 MULT, 001 MULTU, 010 MFHI, 011 MFLO, 100 MTHI, 101 MTLO, 11x no-op
- `rs_data` in WIDTH: first source operand
- `rt_data` in WIDTH: second source operand
- `stall` out 1: high while a multiply is in flight
- `rd_data` out WIDTH: MFHI/MFLO result
- `rd_valid` out 1: one-cycle pulse qualifying `rd_data`
- `mul_start` out 1: one-cycle launch pulse
- `mul_a` out WIDTH: registered operand to multiplier
- `mul_b` out WIDTH: registered operand to multiplier
- `mul_signed` out 1: 1 = MULT, 0 = MULTU
- `mul_done` in 1: multiplier result valid, one-cycle pulse
- `mul_product` in 2*WIDTH: product, {hi,lo}
- `hi` out WIDTH: current HI register
- `lo` out WIDTH: current LO register
- `err` out 1: sticky timeout flag

## Operation
- Op accepted when `op_valid && !stall`; op codes 11x are ignored.
- FSM states:
  - IDLE: accepting ops. Accepted MULT/MULTU registers `mul_a`←`rs_data`, `mul_b`←`rt_data`, sets `mul_signed`, then → LAUNCH.
  - LAUNCH: `mul_start`=1 for exactly this cycle, then → WAIT unconditionally. `mul_done` is ignored in LAUNCH.
  - WAIT: on `mul_done`, HI←`mul_product[63:32]`, LO←`mul_product[31:0]`, then → IDLE.
- `stall` = (state != IDLE). Registered-state decode, no combinational path from `op_valid`.
- MFHI/MFLO accepted at edge T: `rd_data`←HI/LO and `rd_valid`=1 during cycle T+1.
- MTHI/MTLO accepted at edge T: HI/LO←`rs_data`, visible on `hi`/`lo` from T+1. MFHI/MFLO in the next cycle returns the new value.
- `mul_done` in IDLE or LAUNCH: ignored, HI/LO unchanged.
- Reset values: state IDLE, `hi`=`lo`=0, `mul_a`=`mul_b`=0, `mul_signed`=0, `mul_start`=0, `rd_data`=0, `rd_valid`=0, `stall`=0, `err`=0.

## Timing
- MULT accepted at edge T: `stall`=1 and `mul_start`=1 in cycle T+1; WAIT from T+2.
- `mul_done` sampled at edge D in WAIT: HI/LO updated at D, `stall`=0 in cycle D+1, and a new op can be accepted at edge D+1.
- Minimum busy time is 2 cycles plus multiplier latency. The multiplier never asserts `mul_done` in the same cycle as `mul_start`.
- Ops presented while `stall`=1 are not consumed. EX must hold `op_valid`/`op_code`/operands stable until accepted.
- Reset mid-multiply: FSM returns to IDLE and HI/LO clear. A stale `mul_done` that arrives later lands in IDLE and is ignored.
- `rd_valid` never asserts for two consecutive cycles from one op.

## Configuration
- `HILO_TIMEOUT_EN` defined:
  - 8-bit counter clears on entering WAIT and increments each WAIT cycle.
  - When the count reaches `TIMEOUT` without `mul_done`: → IDLE, HI/LO unchanged, `err` set.
  - `err` is sticky until reset.
- `HILO_TIMEOUT_EN` undefined: no counter, WAIT waits indefinitely, `err` tied 0.

## Test plan
- Reset, then MULT rs=5 rt=13. Bench multiplier returns after 130 cycles → `mul_start` single pulse in T+1, `stall` high until done, then `hi`=0, `lo`=65, `mul_signed`=1.
- MULTU rs=0xFFFFFFFF rt=2 (stub product 0x00000001_FFFFFFFE) → `hi`=1, `lo`=0xFFFFFFFE. MFHI next cycle → `rd_data`=1, one `rd_valid` pulse.
- MTLO rs=0xDEADBEEF, then MFLO the following cycle → `rd_data`=0xDEADBEEF. `hi` unchanged.
- MFLO held on `op_valid` during a running MULT → not consumed until `stall` falls. Then it returns the new LO (65 for 5×13), not the old value.
- `rst` low 1 cycle during WAIT, then stale `mul_done` with product 0x0000000A_0000000B → `hi`=`lo`=0, `stall`=0, no update.
- With `HILO_TIMEOUT_EN`, TIMEOUT=200, `mul_done` never asserted → `stall` falls and `err`=1 after 200 WAIT cycles, HI/LO keep prior values. Without the macro, `stall` stays high and `err`=0.
